// File: rtl/compositor_pkg.sv
// Shared types, foreground palette contents and the priority encoder helper
// used by the sprite compositor.
package compositor_pkg;

  localparam int RGB_W     = 24;
  localparam int PAL_IDX_W = 5;
  localparam int PAL_DEPTH = 1 << PAL_IDX_W;
  localparam int PRIO_W    = 32;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } prio_t;

  // Entry 0 is the usual transparent index and is never displayed.
  localparam rgb_t FG_PALETTE [PAL_DEPTH] = '{
    24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
    24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF,
    24'h808080, 24'hC0C0C0, 24'h800000, 24'h008000,
    24'h000080, 24'h808000, 24'h008080, 24'h800080,
    24'hFF8000, 24'h80FF00, 24'h0080FF, 24'hFF0080,
    24'h8000FF, 24'h00FF80, 24'h402000, 24'h604020,
    24'hA06040, 24'hE0A080, 24'h202040, 24'h404080,
    24'h6060C0, 24'hF0E0D0, 24'h102030, 24'h302010
  };

  // Lowest set bit wins; scanning downward lets the last hit overwrite.
  function automatic prio_t prio_first(input logic [PRIO_W-1:0] v);
    prio_t r;
    r = '0;
    for (int i = PRIO_W-1; i >= 0; i--) begin
      if (v[i]) begin
        r.found = 1'b1;
        r.idx   = i[4:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fg_palette_lut.sv
// Foreground palette ROM: one read port, registered output.
module fg_palette_lut
  import compositor_pkg::*;
#(
  parameter int IDX_W = PAL_IDX_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [IDX_W-1:0] rd_idx,
  output rgb_t             rd_rgb
);

  always_ff @(posedge Clk) begin
    if (Reset) rd_rgb <= '0;
    else       rd_rgb <= FG_PALETTE[rd_idx];
  end

endmodule

// File: rtl/sprite_compositor.sv
// N-layer sprite compositor: ROM-latency alignment, priority select, palette
// lookup, per-frame flash blanking and sticky player collision flags.
module sprite_compositor
  import compositor_pkg::*;
#(
  parameter int N_LAYERS     = 6,
  parameter int IDX_W        = 5,
  parameter int ROM_LAT      = 1,
  parameter int TRANSP_IDX   = 0,
  parameter int PLAYER_LAYER = 1,
  parameter int FLASH_SHIFT  = 2,
  localparam int LW          = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_tick,
  input  logic [N_LAYERS-1:0]       hit_in,
  input  logic [N_LAYERS*IDX_W-1:0] index_in,
  input  logic [RGB_W-1:0]          bkg_color,
  input  logic [N_LAYERS-1:0]       layer_en,
  input  logic [N_LAYERS-1:0]       flash_mask,
  output logic [RGB_W-1:0]          rgb_out,
  output logic                      top_valid,
  output logic [LW-1:0]             top_layer,
  output logic [N_LAYERS-1:0]       coll_status
);

  localparam int STAGES = ROM_LAT + 1;

  logic [ROM_LAT-1:0][N_LAYERS-1:0] hit_dly;
  logic [N_LAYERS-1:0]              hit_d;
  logic [N_LAYERS-1:0][IDX_W-1:0]   idx;
  logic [N_LAYERS-1:0]              opaque, coll_now;
  logic [STAGES:0]                  vld_pipe;
  logic [7:0]                       frame_cnt;
  logic                             flash_phase;
  prio_t                            win;

  logic             s1_valid, s2_valid;
  logic [LW-1:0]    s1_layer, s2_layer;
  logic [IDX_W-1:0] s1_idx;
  rgb_t             s1_bkg, s2_bkg, pal_rgb;
  logic [N_LAYERS-1:0] coll_acc;

  assign idx   = index_in;
  assign hit_d = hit_dly[ROM_LAT-1];

  // Hit flags wait here for the sprite ROM data.
  generate
    if (ROM_LAT == 1) begin : g_dly1
      always_ff @(posedge Clk) begin
        if (Reset) hit_dly <= '0;
        else       hit_dly <= hit_in;
      end
    end else begin : g_dlyn
      always_ff @(posedge Clk) begin
        if (Reset) hit_dly <= '0;
        else       hit_dly <= {hit_dly[ROM_LAT-2:0], hit_in};
      end
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset)           frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= frame_cnt + 8'd1;
  end

  assign flash_phase = frame_cnt[FLASH_SHIFT];

  generate
    for (genvar i = 0; i < N_LAYERS; i++) begin : g_layer
      assign opaque[i] = hit_d[i] & layer_en[i] & (idx[i] != IDX_W'(TRANSP_IDX))
                       & ~(flash_mask[i] & flash_phase);
      if (i == PLAYER_LAYER) begin : g_self
        assign coll_now[i] = 1'b0;
      end else begin : g_other
        assign coll_now[i] = opaque[PLAYER_LAYER] & opaque[i];
      end
    end
  endgenerate

  assign win = prio_first(PRIO_W'(opaque));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_layer <= '0;
      s1_idx   <= '0;
      s1_bkg   <= '0;
      s2_valid <= 1'b0;
      s2_layer <= '0;
      s2_bkg   <= '0;
    end else begin
      s1_valid <= win.found;
      s1_layer <= win.found ? LW'(win.idx) : '0;
      s1_idx   <= win.found ? idx[LW'(win.idx)] : IDX_W'(TRANSP_IDX);
      s1_bkg   <= bkg_color;
      s2_valid <= s1_valid;
      s2_layer <= s1_layer;
      s2_bkg   <= s1_bkg;
    end
  end

  fg_palette_lut #(.IDX_W(IDX_W)) u_pal (
    .Clk    (Clk),
    .Reset  (Reset),
    .rd_idx (s1_idx),
    .rd_rgb (pal_rgb)
  );

  // Output stays black until a post-reset pixel has crossed the whole pipe.
  always_ff @(posedge Clk) begin
    if (Reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
  end

  assign rgb_out   = !vld_pipe[STAGES] ? '0 : (s2_valid ? pal_rgb : s2_bkg);
  assign top_valid = s2_valid;
  assign top_layer = s2_layer;

  // A pixel coincident with the tick belongs to the frame being closed.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      coll_acc    <= '0;
      coll_status <= '0;
    end else if (frame_tick) begin
      coll_status <= coll_acc | coll_now;
      coll_acc    <= '0;
    end else begin
      coll_acc    <= coll_acc | coll_now;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with default parameters.
module tb_sprite_compositor;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_tick;
  logic [5:0]  hit_in;
  logic [29:0] index_in;
  logic [23:0] bkg_color;
  logic [5:0]  layer_en;
  logic [5:0]  flash_mask;
  logic [23:0] rgb_out;
  logic        top_valid;
  logic [2:0]  top_layer;
  logic [5:0]  coll_status;

  int checks   = 0;
  int failures = 0;

  sprite_compositor dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .hit_in      (hit_in),
    .index_in    (index_in),
    .bkg_color   (bkg_color),
    .layer_en    (layer_en),
    .flash_mask  (flash_mask),
    .rgb_out     (rgb_out),
    .top_valid   (top_valid),
    .top_layer   (top_layer),
    .coll_status (coll_status)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] iv(input int la, input logic [4:0] va,
                                     input int lb, input logic [4:0] vb);
    logic [5:0][4:0] t;
    t = '0;
    t[la] = va;
    t[lb] = vb;
    return t;
  endfunction

  // Hit in one cycle, ROM data one cycle later; returns just after the
  // edge that presents the pixel on rgb_out.
  task automatic pix(input logic [5:0] h, input logic [29:0] ix, input logic [23:0] bg);
    hit_in = h;
    step();
    hit_in    = '0;
    index_in  = ix;
    bkg_color = bg;
    step();
    index_in  = '0;
    bkg_color = '0;
    step();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    Reset      = 1'b1;
    frame_tick = 1'b0;
    hit_in     = '0;
    index_in   = '0;
    bkg_color  = '0;
    layer_en   = '1;
    flash_mask = '0;
    step();
    step();
    Reset = 1'b0;
    chk("rst_rgb",   32'(rgb_out),     32'h0);
    chk("rst_valid", 32'(top_valid),   32'h0);
    chk("rst_layer", 32'(top_layer),   32'h0);
    chk("rst_coll",  32'(coll_status), 32'h0);

    // Flash on layer 2, phase from frame counter bit 2
    flash_mask = 6'b000100;
    pix(6'b000100, iv(2, 5'd2, 2, 5'd2), 24'hABCDEF);
    chk("flash_f0_valid", 32'(top_valid), 32'h1);
    chk("flash_f0_rgb",   32'(rgb_out),   32'hFF0000);
    repeat (3) tick();
    pix(6'b000100, iv(2, 5'd2, 2, 5'd2), 24'hABCDEF);
    chk("flash_f3_rgb",   32'(rgb_out),   32'hFF0000);
    tick();
    pix(6'b000100, iv(2, 5'd2, 2, 5'd2), 24'hABCDEF);
    chk("flash_f4_valid", 32'(top_valid), 32'h0);
    chk("flash_f4_rgb",   32'(rgb_out),   32'hABCDEF);
    repeat (3) tick();
    pix(6'b000100, iv(2, 5'd2, 2, 5'd2), 24'hABCDEF);
    chk("flash_f7_rgb",   32'(rgb_out),   32'hABCDEF);
    tick();
    pix(6'b000100, iv(2, 5'd2, 2, 5'd2), 24'hABCDEF);
    chk("flash_f8_rgb",   32'(rgb_out),   32'hFF0000);
    chk("flash_f8_layer", 32'(top_layer), 32'h2);
    flash_mask = '0;

    // Priority
    pix(6'b000110, iv(1, 5'd3, 2, 5'd7), 24'h0);
    chk("prio_valid", 32'(top_valid), 32'h1);
    chk("prio_layer", 32'(top_layer), 32'h1);
    chk("prio_rgb",   32'(rgb_out),   32'h00FF00);

    // All layers hit: layer 0 wins
    pix(6'b111111, 30'b00110_00101_00100_00011_00010_00001, 24'h0);
    chk("all_layer", 32'(top_layer), 32'h0);
    chk("all_rgb",   32'(rgb_out),   32'hFFFFFF);

    // Transparency fall-through
    pix(6'b000011, iv(0, 5'd0, 1, 5'd4), 24'h123456);
    chk("fall_layer", 32'(top_layer), 32'h1);
    chk("fall_rgb",   32'(rgb_out),   32'h0000FF);
    pix(6'b000001, iv(0, 5'd0, 0, 5'd0), 24'h123456);
    chk("bkg_valid", 32'(top_valid), 32'h0);
    chk("bkg_rgb",   32'(rgb_out),   32'h123456);

    // Layer enable
    layer_en = 6'b111110;
    pix(6'b010001, iv(0, 5'd5, 4, 5'd9), 24'h0);
    chk("en_layer", 32'(top_layer), 32'h4);
    chk("en_rgb",   32'(rgb_out),   32'hC0C0C0);
    layer_en = '1;

    // Collision
    tick();
    pix(6'b001010, iv(1, 5'd3, 3, 5'd8), 24'h0);
    tick();
    chk("coll_1_3", 32'(coll_status), 32'h08);
    tick();
    chk("coll_clear", 32'(coll_status), 32'h00);
    hit_in = 6'b001010;
    step();
    hit_in     = '0;
    index_in   = iv(1, 5'd3, 3, 5'd8);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    index_in   = '0;
    chk("coll_on_tick", 32'(coll_status), 32'h08);
    tick();
    chk("coll_after_tick", 32'(coll_status), 32'h00);

    // Disabled layer never collides
    layer_en = 6'b111110;
    pix(6'b000011, iv(0, 5'd5, 1, 5'd6), 24'h0);
    chk("en_coll_rgb", 32'(rgb_out), 32'h00FFFF);
    tick();
    chk("en_coll_status", 32'(coll_status), 32'h00);
    layer_en = '1;

    // Reset mid-stream
    for (int c = 0; c < 8; c++) begin
      hit_in    = 6'($urandom);
      index_in  = 30'($urandom);
      bkg_color = 24'($urandom);
      step();
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("mid_rst_rgb",   32'(rgb_out),     32'h0);
    chk("mid_rst_valid", 32'(top_valid),   32'h0);
    chk("mid_rst_coll",  32'(coll_status), 32'h0);
    hit_in    = 6'b000010;
    index_in  = 30'($urandom);
    bkg_color = 24'h777777;
    step();
    chk("mid_rst_black1", 32'(rgb_out), 32'h0);
    hit_in    = '0;
    index_in  = iv(1, 5'd4, 1, 5'd4);
    bkg_color = 24'h777777;
    step();
    chk("mid_rst_black2", 32'(rgb_out), 32'h0);
    index_in  = '0;
    bkg_color = '0;
    step();
    chk("resume_rgb",   32'(rgb_out),     32'h0000FF);
    chk("resume_layer", 32'(top_layer),   32'h1);
    chk("resume_coll",  32'(coll_status), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised N-layer pixel compositor that replaces the hand-written priority mux in the game top level.
- Per pixel it takes the per-layer sprite hit flags and the palette indices returned by the sprite ROMs. It then:
  - aligns them through a configurable ROM-latency delay line,
  - picks the highest-priority opaque layer,
  - looks up the shared foreground palette,
  - outputs registered 24-bit RGB.
- It adds three things: per-layer enable, per-layer damage-flash blanking, and per-frame sticky player-to-sprite pixel collision flags for game logic.

Parameters:
- N_LAYERS, 6: number of sprite layers. Layer 0 has the highest priority.
- IDX_W, 5: palette index width.
- ROM_LAT, 1: cycles from hit_in to the matching index_in/bkg_color. Must be at least 1.
- TRANSP_IDX, 0: palette index treated as transparent.
- PLAYER_LAYER, 1: layer whose overlaps are reported in coll_status.
- FLASH_SHIFT, 2: flash phase is bit FLASH_SHIFT of the frame counter.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse at frame start, derived from the VGA_VS edge.
- hit_in  in  N_LAYERS  per-layer "pixel inside sprite box", valid in the same cycle the ROM address is issued.
- index_in  in  N_LAYERS*IDX_W  packed palette indices, layer i at [i*IDX_W +: IDX_W], arriving ROM_LAT cycles after hit_in.
- bkg_color  in  24  background RGB, aligned with index_in.
- layer_en  in  N_LAYERS  layer enable; a disabled layer is always transparent.
- flash_mask  in  N_LAYERS  layers that blank while the flash phase is 1.
- rgb_out  out  24  composited colour, {R,G,B}.
- top_valid  out  1  a sprite won the current pixel; 0 means background.
- top_layer  out  $clog2(N_LAYERS)  winning layer number, aligned with rgb_out.
- coll_status  out  N_LAYERS  sticky collision flags for the previous frame. Bit PLAYER_LAYER always reads 0.

Behaviour:
- Reset: rgb_out = 0, top_valid = 0, top_layer = 0, coll_status = 0. Internal state also clears: delay line = 0, frame counter = 0, collision accumulator = 0.
- Delay line: hit_in passes through ROM_LAT registers; hit_d is the delayed copy.
- Stage C (combinational on hit_d/index_in):
  - opaque[i] = hit_d[i] & layer_en[i] & (idx[i] != TRANSP_IDX) & ~(flash_mask[i] & flash_phase).
  - Winner = lowest i with opaque[i] set.
  - Registered into S1: sel_valid, sel_layer, sel_idx (TRANSP_IDX when there is no winner), bkg_color.
- S2:
  - Palette sub-module read of sel_idx, 1-cycle latency.
  - rgb_out = sel_valid ? palette : bkg_color_d.
  - top_valid and top_layer are delayed to match.
- Latency:
  - hit_in to rgb_out: ROM_LAT + 2 cycles.
  - index_in/bkg_color to rgb_out: 2 cycles.
  - Fully pipelined, one pixel per cycle, no stalls.
- Frame counter:
  - 8-bit, increments on frame_tick and wraps 255 to 0.
  - flash_phase = frame_cnt[FLASH_SHIFT].
  - A phase change takes effect on the first stage-C cycle after the tick.
- Collision:
  - coll_now[i] = opaque[PLAYER_LAYER] & opaque[i] for i != PLAYER_LAYER.
  - Every cycle: coll_acc |= coll_now.
  - On frame_tick: coll_status <= coll_acc | coll_now, and coll_acc <= 0. A pixel coincident with the tick is credited to the closing frame.
  - Flashed or disabled layers never collide.
- Reset mid-frame:
  - All pipeline stages flush to zero.
  - rgb_out is black for ROM_LAT + 2 cycles.
  - coll_status stays 0 until the next tick.
- Simultaneous hits on all layers: layer 0 wins.
- All layers transparent: background is shown.
- TRANSP_IDX pixels from a higher-priority layer fall through to the next opaque layer. This covers the attack-over-player case.

Decomposition:
- Package compositor_pkg holds:
  - RGB_W = 24,
  - typedef rgb_t,
  - the palette constant table (2^IDX_W entries of rgb_t),
  - function prio_first(vector) returning {found, index}.
- Sub-module fg_palette_lut: single read port, registered output, reads the package table.
- The delay line is an inline generate, not a sub-module.

Test Plan:
- Priority: N_LAYERS = 6, ROM_LAT = 1. hit_in = 6'b000110, idx1 = 3, idx2 = 7, all enabled → 3 cycles later top_valid = 1, top_layer = 1, rgb_out = palette[3].
- Transparency fall-through: hit_in = 6'b000011, idx0 = 0, idx1 = 4 → top_layer = 1, rgb_out = palette[4]. Same with hit_in = 6'b000001 → top_valid = 0, rgb_out = bkg_color (0x123456).
- Flash: flash_mask = 6'b000100, layer 2 alone opaque, FLASH_SHIFT = 2. Issue 4 frame_ticks → layer 2 is visible before the 4th tick and shows background after it until the 8th tick.
- Collision: one cycle with layers 1 and 3 opaque, then frame_tick → coll_status = 6'b001000. A second tick with no overlap → coll_status = 0. An overlap in the tick cycle itself is captured.
- Layer enable: layer_en[0] = 0 with layer 0 opaque over layer 4 → top_layer = 4, and no collision is recorded for layer 0.
- Reset mid-stream: a continuous random pixel stream with Reset asserted for 1 cycle → next cycle rgb_out = 0, top_valid = 0, coll_status = 0. Correct output resumes ROM_LAT + 2 cycles after deassertion.
